// File: rtl/wb_split_pkg.sv
// Shared types and constants for the Wishbone 1-to-N slave splitter.
// Holds the FSM state type, default address windows and the dead-data pattern.
package wb_split_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StResp
  } state_e;

  localparam logic [31:0] FirBase   = 32'h3000_0000;
  localparam logic [31:0] FirMask   = 32'hFFF0_0000;
  localparam logic [31:0] MmBase    = 32'h3010_0000;
  localparam logic [31:0] MmMask    = 32'hFFF0_0000;
  localparam logic [31:0] ExmemBase = 32'h3800_0000;
  localparam logic [31:0] ExmemMask = 32'hFF00_0000;

  localparam logic [31:0] DeadData  = 32'hDEAD_BEEF;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

endpackage

// File: rtl/wb_addr_decode.sv
// Combinational base/mask address decoder: per-slave hit vector,
// lowest-index-wins slave index, and a miss flag when nothing matches.
module wb_addr_decode
  import wb_split_pkg::*;
#(
  parameter int unsigned         N_SLV    = 3,
  parameter int unsigned         ADDR_W   = 32,
  parameter int unsigned         IDX_W    = (N_SLV > 1) ? clog2(N_SLV) : 1,
  parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE = '0,
  parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK = '0
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic [N_SLV-1:0]  hit_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic              miss_o
);

  for (genvar g = 0; g < N_SLV; g++) begin : g_hit
    assign hit_o[g] = ((addr_i ^ SLV_BASE[g*ADDR_W +: ADDR_W])
                       & SLV_MASK[g*ADDR_W +: ADDR_W]) == '0;
  end

  // Walk downwards so the lowest matching index is the last one written.
  always_comb begin
    idx_o = '0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if (hit_o[i]) idx_o = IDX_W'(i);
    end
  end

  assign miss_o = ~|hit_o;

endmodule

// File: rtl/wb_slave_splitter.sv
// Wishbone classic 1-to-N slave splitter with latched slave index, miss error
// response, BUSY watchdog timeout and saturating error counter.
module wb_slave_splitter
  import wb_split_pkg::*;
#(
  parameter int unsigned             N_SLV     = 3,
  parameter int unsigned             DATA_W    = 32,
  parameter int unsigned             ADDR_W    = 32,
  parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE  = {ExmemBase, MmBase, FirBase},
  parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK  = {ExmemMask, MmMask, FirMask},
  parameter int unsigned             TIMEOUT   = 255,
  parameter logic [31:0]             DEAD_DATA = DeadData
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     wbs_stb_i,
  input  logic                     wbs_cyc_i,
  input  logic                     wbs_we_i,
  input  logic [3:0]               wbs_sel_i,
  input  logic [DATA_W-1:0]        wbs_dat_i,
  input  logic [ADDR_W-1:0]        wbs_adr_i,
  output logic                     wbs_ack_o,
  output logic [DATA_W-1:0]        wbs_dat_o,
  output logic                     wbs_err_o,
  output logic [N_SLV-1:0]         s_stb_o,
  output logic [N_SLV-1:0]         s_cyc_o,
  output logic [N_SLV-1:0]         s_we_o,
  output logic [4*N_SLV-1:0]       s_sel_o,
  output logic [DATA_W-1:0]        s_dat_o,
  output logic [ADDR_W-1:0]        s_adr_o,
  input  logic [N_SLV-1:0]         s_ack_i,
  input  logic [N_SLV*DATA_W-1:0]  s_dat_i,
  output logic [7:0]               err_cnt_o,
  output logic                     timeout_irq
);

  localparam int unsigned IdxW       = (N_SLV > 1) ? clog2(N_SLV) : 1;
  localparam logic [15:0] TimeoutCnt = 16'(TIMEOUT - 1);

  logic [N_SLV-1:0] dec_hit;
  logic [IdxW-1:0]  dec_idx;
  logic             dec_miss;

  wb_addr_decode #(
    .N_SLV    (N_SLV),
    .ADDR_W   (ADDR_W),
    .IDX_W    (IdxW),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_decode (
    .addr_i (wbs_adr_i),
    .hit_o  (dec_hit),
    .idx_o  (dec_idx),
    .miss_o (dec_miss)
  );

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              irq_q, irq_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic              err_event;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    dat_d     = dat_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    irq_d     = 1'b0;
    err_event = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          if (dec_miss) begin
            dat_d     = DATA_W'(DEAD_DATA);
            ack_d     = 1'b1;
            err_d     = 1'b1;
            err_event = 1'b1;
            state_d   = StResp;
          end else if (|dec_hit) begin
            idx_d   = dec_idx;
            cnt_d   = '0;
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        // Ack is checked before the watchdog so a coincident ack wins.
        if (!wbs_cyc_i) begin
          state_d = StIdle;
        end else if (s_ack_i[idx_q]) begin
          dat_d   = s_dat_i[idx_q*DATA_W +: DATA_W];
          ack_d   = 1'b1;
          state_d = StResp;
        end else if (cnt_q == TimeoutCnt) begin
          dat_d     = DATA_W'(DEAD_DATA);
          ack_d     = 1'b1;
          err_d     = 1'b1;
          irq_d     = 1'b1;
          err_event = 1'b1;
          state_d   = StResp;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_event && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      cnt_q     <= '0;
      dat_q     <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      irq_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      dat_q     <= dat_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      irq_q     <= irq_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_comb begin
    s_stb_o = '0;
    s_cyc_o = '0;
    s_we_o  = '0;
    s_sel_o = '0;
    if (state_q == StBusy) begin
      s_stb_o[idx_q]          = wbs_stb_i;
      s_cyc_o[idx_q]          = wbs_cyc_i;
      s_we_o[idx_q]           = wbs_we_i;
      s_sel_o[idx_q*4 +: 4]   = wbs_sel_i;
    end
  end

  assign s_dat_o     = wbs_dat_i;
  assign s_adr_o     = wbs_adr_i;
  assign wbs_ack_o   = ack_q;
  assign wbs_err_o   = err_q;
  assign wbs_dat_o   = dat_q;
  assign timeout_irq = irq_q;
  assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_wb_slave_splitter.sv
// Directed bench for wb_slave_splitter: expected responses are queued when a
// transaction is launched and checked when the master ack appears.
module tb_wb_slave_splitter;

  localparam int unsigned NSlv = 3;

  logic              clk;
  logic              rst;
  logic              stb, cyc, we;
  logic [3:0]        sel;
  logic [31:0]       wdat, adr;
  logic              ack, err, irq;
  logic [31:0]       rdat;
  logic [NSlv-1:0]   s_stb, s_cyc, s_we, s_ack;
  logic [4*NSlv-1:0] s_sel;
  logic [31:0]       s_dat_o, s_adr_o;
  logic [NSlv*32-1:0] s_dat_i;
  logic [7:0]        err_cnt;

  wb_slave_splitter #(
    .N_SLV   (NSlv),
    .TIMEOUT (8)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wbs_stb_i   (stb),
    .wbs_cyc_i   (cyc),
    .wbs_we_i    (we),
    .wbs_sel_i   (sel),
    .wbs_dat_i   (wdat),
    .wbs_adr_i   (adr),
    .wbs_ack_o   (ack),
    .wbs_dat_o   (rdat),
    .wbs_err_o   (err),
    .s_stb_o     (s_stb),
    .s_cyc_o     (s_cyc),
    .s_we_o      (s_we),
    .s_sel_o     (s_sel),
    .s_dat_o     (s_dat_o),
    .s_adr_o     (s_adr_o),
    .s_ack_i     (s_ack),
    .s_dat_i     (s_dat_i),
    .err_cnt_o   (err_cnt),
    .timeout_irq (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] dat;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_resp(input logic [31:0] d, input logic e);
    exp_t x;
    x.dat = d;
    x.err = e;
    sb.push_back(x);
  endtask

  task automatic check_resp(input string tag);
    exp_t x;
    chk({tag, "_ack"}, 32'(ack), 32'd1);
    chk({tag, "_sb"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      x = sb.pop_front();
      chk({tag, "_dat"}, rdat, x.dat);
      chk({tag, "_err"}, 32'(err), 32'(x.err));
    end
  endtask

  task automatic wait_resp(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (ack !== 1'b1 && n < max_cyc) begin
      tick();
      n++;
    end
    check_resp(tag);
  endtask

  task automatic start(input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic [3:0] s);
    adr  = a;
    we   = w;
    wdat = d;
    sel  = s;
    cyc  = 1'b1;
    stb  = 1'b1;
  endtask

  task automatic stop();
    cyc = 1'b0;
    stb = 1'b0;
    we  = 1'b0;
  endtask

  initial begin
    int exp_cnt;
    rst = 1'b1;
    stop();
    sel = '0; wdat = '0; adr = '0;
    s_ack = '0; s_dat_i = '0;
    tick(); tick();
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_dat", rdat, 32'd0);
    chk("rst_errcnt", 32'(err_cnt), 32'd0);
    chk("rst_stb", 32'(s_stb), 32'd0);
    rst = 1'b0;
    tick();

    // Write to slave 0, ack after two BUSY cycles.
    s_dat_i[0 +: 32] = 32'h0000_A5A5;
    start(32'h3000_0004, 1'b1, 32'h1234_5678, 4'hF);
    expect_resp(32'h0000_A5A5, 1'b0);
    chk("wr_idle_stb", 32'(s_stb), 32'd0);
    tick();
    chk("wr_stb", 32'(s_stb), 32'b001);
    chk("wr_cyc", 32'(s_cyc), 32'b001);
    chk("wr_we", 32'(s_we), 32'b001);
    chk("wr_sel", 32'(s_sel), 32'h00F);
    chk("wr_sdat", s_dat_o, 32'h1234_5678);
    chk("wr_sadr", s_adr_o, 32'h3000_0004);
    tick();
    chk("wr_noack_yet", 32'(ack), 32'd0);
    s_ack = 3'b001;
    tick();
    s_ack = '0;
    check_resp("wr");
    stop();
    tick();
    chk("wr_ack_pulse", 32'(ack), 32'd0);
    chk("wr_stb_off", 32'(s_stb), 32'd0);

    // Read slave 1; slave 0 acks spuriously, alone first then together.
    s_dat_i[0 +: 32]  = 32'hBAD0_0000;
    s_dat_i[32 +: 32] = 32'hCAFE_0001;
    start(32'h3010_0000, 1'b0, 32'h0, 4'hF);
    expect_resp(32'hCAFE_0001, 1'b0);
    tick();
    chk("rd1_stb", 32'(s_stb), 32'b010);
    chk("rd1_sel", 32'(s_sel), 32'h0F0);
    s_ack = 3'b001;
    tick();
    chk("rd1_stray_ignored", 32'(ack), 32'd0);
    chk("rd1_still_busy", 32'(s_stb), 32'b010);
    s_ack = 3'b011;
    tick();
    s_ack = '0;
    check_resp("rd1");
    stop();
    tick();

    // Unmapped address.
    start(32'h4000_0000, 1'b0, 32'h0, 4'hF);
    expect_resp(32'hDEAD_BEEF, 1'b1);
    chk("miss_idle_stb", 32'(s_stb), 32'd0);
    tick();
    chk("miss_stb", 32'(s_stb), 32'd0);
    check_resp("miss");
    chk("miss_errcnt", 32'(err_cnt), 32'd1);
    stop();
    tick();
    chk("miss_ack_pulse", 32'(ack), 32'd0);
    chk("miss_dat_hold", rdat, 32'hDEAD_BEEF);

    // Slave 2: first run never acks, second run acks on the last allowed cycle.
    s_dat_i[64 +: 32] = 32'h5A5A_0002;
    for (int run = 0; run < 2; run++) begin
      start(32'h3800_0010, 1'b0, 32'h0, 4'h3);
      if (run == 0) expect_resp(32'hDEAD_BEEF, 1'b1);
      else          expect_resp(32'h5A5A_0002, 1'b0);
      tick();
      for (int k = 1; k <= 8; k++) begin
        chk($sformatf("to%0d_stb_c%0d", run, k), 32'(s_stb), 32'b100);
        chk($sformatf("to%0d_ack_c%0d", run, k), 32'(ack), 32'd0);
        if (run == 1 && k == 8) s_ack = 3'b100;
        tick();
      end
      s_ack = '0;
      check_resp($sformatf("to%0d", run));
      chk($sformatf("to%0d_irq", run), 32'(irq), (run == 0) ? 32'd1 : 32'd0);
      chk($sformatf("to%0d_errcnt", run), 32'(err_cnt), 32'd2);
      chk($sformatf("to%0d_stb_drop", run), 32'(s_stb), 32'd0);
      stop();
      tick();
      chk($sformatf("to%0d_irq_pulse", run), 32'(irq), 32'd0);
    end

    // Abort in BUSY, then a normal read.
    start(32'h3000_0000, 1'b0, 32'h0, 4'hF);
    tick(); tick(); tick();
    chk("abort_stb_c3", 32'(s_stb), 32'b001);
    stop();
    tick();
    chk("abort_stb_off", 32'(s_stb), 32'd0);
    chk("abort_cyc_off", 32'(s_cyc), 32'd0);
    chk("abort_noack", 32'(ack), 32'd0);
    tick();
    chk("abort_noack2", 32'(ack), 32'd0);
    s_dat_i[0 +: 32] = 32'h1111_0000;
    s_ack = 3'b001;
    start(32'h3000_0000, 1'b0, 32'h0, 4'hF);
    expect_resp(32'h1111_0000, 1'b0);
    wait_resp("post_abort", 10);
    s_ack = '0;
    stop();
    tick();

    // Reset mid-BUSY.
    start(32'h3010_0000, 1'b0, 32'h0, 4'hF);
    tick();
    chk("rstb_stb", 32'(s_stb), 32'b010);
    rst = 1'b1;
    tick();
    chk("rstb_stb_off", 32'(s_stb), 32'd0);
    chk("rstb_ack", 32'(ack), 32'd0);
    chk("rstb_dat", rdat, 32'd0);
    chk("rstb_errcnt", 32'(err_cnt), 32'd0);
    stop();
    rst = 1'b0;
    tick();
    chk("rstb_ack_after", 32'(ack), 32'd0);

    // 300 misses: counter saturates at 255.
    exp_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      start(32'h4000_0000 + 32'(i), 1'b0, 32'h0, 4'hF);
      tick();
      stop();
      if (exp_cnt < 255) exp_cnt++;
      chk($sformatf("sat_%0d", i), 32'(err_cnt), 32'(exp_cnt));
      tick();
    end

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
